// File: rtl/cam_frame_capture.sv
// cam_frame_capture: OV7670 DVP capture front end feeding a frame-buffer
// SPRAM write port. Keeps one byte per two-byte pixel, generates
// line-aligned addresses and freezes the buffer after each complete frame
// until the SPI host has finished a read (ssel low then high again).
module cam_frame_capture #(
  parameter int H_BYTES  = 640,
  parameter int V_LINES  = 240,
  parameter int BYTE_SEL = 0,
  parameter int ADDR_W   = 17
) (
  input  logic              pclk,
  input  logic              reset_n,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        pdata,
  input  logic              ssel,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_done,
  output logic              frame_valid,
  output logic [7:0]        frame_cnt
);

  localparam int                LINE_W    = $clog2(V_LINES + 1);
  localparam logic [15:0]       H_MAX     = 16'(H_BYTES);
  localparam logic [LINE_W-1:0] V_MAX     = LINE_W'(V_LINES);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_BYTES / 2);
  localparam logic              SEL       = 1'(BYTE_SEL);

  typedef enum logic [1:0] {WAIT_VS, ARM, CAPTURE, HOLD} state_t;

  state_t state, state_nx;

  logic              q_vsync, q_vsync_d, q_href, q_href_d;
  logic [7:0]        q_pdata;
  logic              ssel_m, ssel_s;
  logic [15:0]       bcnt;
  logic [LINE_W-1:0] line;
  logic [ADDR_W-1:0] line_base;
  logic              ssel_seen;

  logic vs_rise, vs_fall, href_fall;
  logic wr_go, frame_end, release_hold;

  assign vs_rise   =  q_vsync & ~q_vsync_d;
  assign vs_fall   = ~q_vsync &  q_vsync_d;
  assign href_fall = ~q_href  &  q_href_d;

  // Register camera inputs once, delayed copies for edge detect, 2-flop ssel sync.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      q_vsync   <= 1'b0;
      q_vsync_d <= 1'b0;
      q_href    <= 1'b0;
      q_href_d  <= 1'b0;
      q_pdata   <= 8'h00;
      ssel_m    <= 1'b1;
      ssel_s    <= 1'b1;
    end else begin
      q_vsync   <= vsync;
      q_vsync_d <= q_vsync;
      q_href    <= href;
      q_href_d  <= q_href;
      q_pdata   <= pdata;
      ssel_m    <= ssel;
      ssel_s    <= ssel_m;
    end
  end

  // State register.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) state <= WAIT_VS;
    else          state <= state_nx;
  end

  // Next state plus per-cycle write / frame-complete / release decisions.
  always_comb begin
    state_nx     = state;
    wr_go        = 1'b0;
    frame_end    = 1'b0;
    release_hold = 1'b0;
    case (state)
      WAIT_VS: if (vs_rise && ssel_s) state_nx = ARM;
      ARM:     if (vs_fall) state_nx = CAPTURE;
      CAPTURE: begin
        wr_go = q_href && (bcnt < H_MAX) && (bcnt[0] == SEL) && (line < V_MAX);
        if (!ssel_s) begin
          // Host began reading mid-capture: drop this frame quietly.
          state_nx = WAIT_VS;
        end else if (vs_rise) begin
          state_nx  = HOLD;
          frame_end = 1'b1;
        end
      end
      HOLD: begin
        // A vsync edge coinciding with release is deliberately ignored.
        if (ssel_seen && ssel_s) begin
          state_nx     = WAIT_VS;
          release_hold = 1'b1;
        end
      end
      default: state_nx = WAIT_VS;
    endcase
  end

  // Byte/line counters; line_base stops advancing once past the last kept line.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      bcnt      <= '0;
      line      <= '0;
      line_base <= '0;
      ssel_seen <= 1'b0;
    end else begin
      if (!q_href)              bcnt <= '0;
      else if (bcnt != H_MAX)   bcnt <= bcnt + 16'd1;

      if (state == ARM) begin
        line      <= '0;
        line_base <= '0;
      end else if (state == CAPTURE && href_fall && line != V_MAX) begin
        line      <= line + 1'b1;
        line_base <= line_base + LINE_STEP;
      end

      if (state != HOLD)  ssel_seen <= 1'b0;
      else if (!ssel_s)   ssel_seen <= 1'b1;
    end
  end

  // Registered write port and frame status.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= 8'h00;
      frame_done  <= 1'b0;
      frame_valid <= 1'b0;
      frame_cnt   <= 8'h00;
    end else begin
      wr_en      <= wr_go;
      frame_done <= frame_end;
      if (wr_go) begin
        wr_addr <= line_base + ADDR_W'(bcnt >> 1);
        wr_data <= q_pdata;
      end
      if (frame_end) begin
        frame_valid <= 1'b1;
        frame_cnt   <= frame_cnt + 8'd1;
      end else if (release_hold) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/cam_frame_capture.md
# cam_frame_capture

Capture front end between the OV7670 parallel pixel bus and the frame-buffer SPRAM write port. Registers and windows the DVP stream (VSYNC/HREF/PDATA), keeps one byte of each two-byte pixel, and generates line-aligned write addresses. Freezes the buffer after a complete frame until the SPI host has finished reading it, so the host never sees a torn frame.

## Interface
Parameters:
- H_BYTES, 640: bytes accepted per line (2 per pixel); must be even.
- V_LINES, 240: lines accepted per frame.
- BYTE_SEL, 0: byte phase kept within each pixel pair (0 = first byte after HREF rise).
- ADDR_W, 17: write address width; (H_BYTES/2)*V_LINES must be ≤ 2^ADDR_W.

Ports:
- pclk  in  1  camera pixel clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- vsync  in  1  camera VSYNC, active high.
- href  in  1  camera HREF, active high.
- pdata  in  8  camera pixel byte.
- ssel  in  1  SPI slave select, active low, asynchronous to pclk.
- wr_en  out  1  SPRAM write strobe.
- wr_addr  out  ADDR_W  SPRAM write address.
- wr_data  out  8  SPRAM write data.
- frame_done  out  1  one-cycle pulse when a frame completes.
- frame_valid  out  1  buffer holds a complete, frozen frame.
- frame_cnt  out  8  completed-frame count, wraps 255→0.

## Operation
- Input stage: vsync, href, pdata registered once (q_vsync, q_href, q_pdata); ssel through a 2-flop synchronizer (ssel_s, reset value 1). Edges are detected on the registered copies.
- Per line: byte counter bcnt clears when q_href is low; phase = bcnt[0]. A byte is written when q_href=1, bcnt < H_BYTES, phase == BYTE_SEL, line < V_LINES and state == CAPTURE.
- Address = line_base + (bcnt>>1). On a q_href falling edge in CAPTURE, line increments and line_base += H_BYTES/2, for short lines too; lines never shift. Bytes past H_BYTES and lines past V_LINES are dropped without writing.
- States:
  - WAIT_VS: on q_vsync rising with ssel_s=1 → ARM; otherwise hold.
  - ARM: clear line and line_base; on q_vsync falling → CAPTURE.
  - CAPTURE: write per the rules above.
    - ssel_s=0 (host started a read mid-capture) → WAIT_VS. Frame discarded, no frame_done.
    - q_vsync rising → HOLD. frame_done pulses, frame_valid←1, frame_cnt++.
  - HOLD: no writes. Record that ssel_s has fallen. After ssel_s falls and later returns to 1 → WAIT_VS with frame_valid←0. A q_vsync rising in the same cycle as release is not consumed; the next edge arms.
- Reset mid-operation: immediate return to WAIT_VS. All counters clear.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, frame_done=0, frame_valid=0, frame_cnt=0. State = WAIT_VS.
- Latency: pdata/href sampled at pclk edge k; wr_en/wr_addr/wr_data are registered outputs valid after edge k+1 (2-cycle pipeline). wr_en is high for exactly one cycle per accepted byte.
- Back-to-back accepted bytes are written on alternate cycles; wr_addr increments by 1 per write within a line.
- frame_done is asserted the cycle after the q_vsync rising edge is detected. frame_valid and frame_cnt update in that same cycle.
- ssel-induced transitions occur 2 cycles after ssel changes (synchronizer) plus 1 cycle of state update.
- Arithmetic: line_base and the address are ADDR_W bits with no wrap. The legality bound from the parameters guarantees no overflow. bcnt is 16 bits and saturates at H_BYTES.

## Test plan
- Nominal frame (H_BYTES=8, V_LINES=2, BYTE_SEL=0; 2 lines of 8 bytes 0x00..0x0F; ssel=1) → writes addr 0..3 with data 00,02,04,06, then addr 4..7 with 08,0A,0C,0E. One frame_done; frame_valid=1; frame_cnt=1.
- Long/short lines (line0 = 12 bytes, line1 = 4 bytes) → line0 writes addr 0..3 only. Line1 writes addr 4,5. No writes at addr 6..7.
- Extra lines (4 lines sent, V_LINES=2) → exactly 8 writes. frame_done only at the next vsync rise.
- Mid-capture abort (ssel pulled low during line1) → writes stop within 3 cycles. No frame_done; frame_valid stays 0; capture resumes on a later frame after ssel returns high.
- Hold/release (frame complete, then 3 more vsync frames with ssel=1) → no writes. After a ssel low pulse ends, frame_valid=0 and the next frame is captured; frame_cnt=2.
- Reset asserted mid-line → all outputs 0 immediately. After reset release, no writes until vsync rises then falls.
